// File: rtl/quad_pkg.sv
// Shared types and constants for the operand issue stage: opcode map,
// ALU control codes, instruction layout and FSM states.
package quad_pkg;

  localparam int DATA_W = 16;
  localparam int NREGS  = 16;
  localparam int REG_W  = 4;

  // Opcode map. Values 0x0..0xB are register-register ALU ops whose
  // opcode is passed straight through as the ALU control.
  typedef enum logic [3:0] {
    OP_ADD     = 4'h0,
    OP_RR_LAST = 4'hB,
    OP_LDI     = 4'hC,
    OP_ADDI    = 4'hD,
    OP_NOP     = 4'hE,
    OP_HALT    = 4'hF
  } opcode_e;

  localparam logic [3:0] ALU_ADD = 4'h0;

  typedef struct packed {
    logic [3:0]       op;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] ra;
    logic [REG_W-1:0] rb;
  } instr_t;

  typedef enum logic {
    ST_RUN,
    ST_HALTED
  } state_e;

  function automatic logic is_reg_reg(input logic [3:0] op);
    return op <= OP_RR_LAST;
  endfunction

endpackage

// File: rtl/operand_issue_if.sv
// Fetch handshake, ALU issue bundle and write-back port of the issue stage.
interface operand_issue_if;
  import quad_pkg::*;

  logic                     instr_valid;
  logic [15:0]              instr;
  logic                     instr_ready;
  logic                     alu_valid;
  logic [3:0]               alu_ctrl;
  logic signed [DATA_W-1:0] op_a;
  logic signed [DATA_W-1:0] op_b;
  logic [REG_W-1:0]         alu_rd;
  logic                     wb_valid;
  logic [REG_W-1:0]         wb_rd;
  logic [DATA_W-1:0]        wb_data;
  logic                     halted;
  logic                     illegal;

  // Issue stage side.
  modport slave (
    input  instr_valid, instr, wb_valid, wb_rd, wb_data,
    output instr_ready, alu_valid, alu_ctrl, op_a, op_b, alu_rd, halted, illegal
  );

  // Fetch / ALU / write-back environment side.
  modport master (
    output instr_valid, instr, wb_valid, wb_rd, wb_data,
    input  instr_ready, alu_valid, alu_ctrl, op_a, op_b, alu_rd, halted, illegal
  );

endinterface

// File: rtl/regfile.sv
// 16 x DATA_W register file: two asynchronous read ports, one synchronous
// write port, r0 hardwired to zero.
module regfile
  import quad_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic [REG_W-1:0]  i_ra_addr,
  output logic [DATA_W-1:0] o_ra_data,
  input  logic [REG_W-1:0]  i_rb_addr,
  output logic [DATA_W-1:0] o_rb_data,
  input  logic              i_we,
  input  logic [REG_W-1:0]  i_wa,
  input  logic [DATA_W-1:0] i_wd
);

  logic [DATA_W-1:0] r_mem [NREGS];

  // Register array update; writes to r0 are dropped.
  // NOTE: the array is flop-based and cleared by the async reset, so it
  // cannot map to a RAM macro; that is intended for a 16-entry file.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
    end else if (i_we && (i_wa != '0)) begin
      r_mem[i_wa] <= i_wd;
    end
  end

  assign o_ra_data = (i_ra_addr == '0) ? '0 : r_mem[i_ra_addr];
  assign o_rb_data = (i_rb_addr == '0) ? '0 : r_mem[i_rb_addr];

endmodule

// File: rtl/operand_issue.sv
// Decode/issue stage: decodes fetch words, checks the per-register
// scoreboard, reads/forwards operands and registers one ALU bundle per
// issued instruction. Write-backs update the register file and scoreboard.
module operand_issue
  import quad_pkg::*;
(
  input  logic            clk,
  input  logic            resetn,
  operand_issue_if.slave  bus
);

  instr_t             w_instr;
  logic               w_is_rr;
  logic               w_uses_ra;
  logic               w_uses_rb;
  logic               w_writes_rd;
  logic [NREGS-1:0]   w_clr_mask;
  logic [NREGS-1:0]   w_pend_eff;
  logic [NREGS-1:0]   w_pend_next;
  logic               w_hazard;
  logic               w_fire;
  logic [DATA_W-1:0]  w_rf_a;
  logic [DATA_W-1:0]  w_rf_b;
  logic [DATA_W-1:0]  w_src_a;
  logic [DATA_W-1:0]  w_src_b;
  logic [3:0]         w_ctrl;
  logic [DATA_W-1:0]  w_op_a;
  logic [DATA_W-1:0]  w_op_b;

  state_e             r_state;
  logic [NREGS-1:0]   r_pend;
  logic               r_alu_valid;
  logic [3:0]         r_alu_ctrl;
  logic [DATA_W-1:0]  r_op_a;
  logic [DATA_W-1:0]  r_op_b;
  logic [REG_W-1:0]   r_alu_rd;
  logic               r_halted;

  assign w_instr = instr_t'(bus.instr);

  regfile u_regfile (
    .clk       (clk),
    .resetn    (resetn),
    .i_ra_addr (w_instr.ra),
    .o_ra_data (w_rf_a),
    .i_rb_addr (w_instr.rb),
    .o_rb_data (w_rf_b),
    .i_we      (bus.wb_valid),
    .i_wa      (bus.wb_rd),
    .i_wd      (bus.wb_data)
  );

  // Decode which register fields the instruction actually uses.
  always_comb begin
    w_is_rr     = is_reg_reg(w_instr.op);
    w_uses_ra   = w_is_rr || (w_instr.op == OP_ADDI);
    w_uses_rb   = w_is_rr;
    w_writes_rd = w_is_rr || (w_instr.op == OP_LDI) || (w_instr.op == OP_ADDI);
  end

  // A register being written back this cycle no longer counts as pending.
  assign w_clr_mask = bus.wb_valid ? (NREGS'(1) << bus.wb_rd) : '0;
  assign w_pend_eff = r_pend & ~w_clr_mask;

  assign w_hazard = (w_uses_ra   && w_pend_eff[w_instr.ra]) ||
                    (w_uses_rb   && w_pend_eff[w_instr.rb]) ||
                    (w_writes_rd && w_pend_eff[w_instr.rd]);

  assign bus.instr_ready = (r_state == ST_RUN) && !w_hazard;
  assign w_fire          = bus.instr_valid && bus.instr_ready;

  // Same-cycle write-back wins over the stale array value; r0 stays zero.
  assign w_src_a = (bus.wb_valid && (bus.wb_rd == w_instr.ra) && (w_instr.ra != '0))
                   ? bus.wb_data : w_rf_a;
  assign w_src_b = (bus.wb_valid && (bus.wb_rd == w_instr.rb) && (w_instr.rb != '0))
                   ? bus.wb_data : w_rf_b;

  // Build the ALU bundle for the instruction at the fetch port.
  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_ctrl = ALU_ADD;
    w_op_a = w_src_a;
    w_op_b = w_src_b;
    if (w_is_rr) begin
      w_ctrl = w_instr.op;
    end else if (w_instr.op == OP_LDI) begin
      w_op_a = '0;
      w_op_b = {{(DATA_W-8){w_instr.ra[3]}}, w_instr.ra, w_instr.rb};
    end else if (w_instr.op == OP_ADDI) begin
      w_op_b = {{(DATA_W-4){w_instr.rb[3]}}, w_instr.rb};
    end
  end

  // Scoreboard next state: clear on write-back, then set on issue so a
  // same-register set wins. r0 is never marked pending.
  always_comb begin
    w_pend_next = r_pend & ~w_clr_mask;
    if (w_fire && w_writes_rd && (w_instr.rd != '0)) begin
      w_pend_next[w_instr.rd] = 1'b1;
    end
  end

  // FSM, scoreboard and registered ALU bundle.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_RUN;
      r_pend      <= '0;
      r_alu_valid <= 1'b0;
      r_alu_ctrl  <= '0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_alu_rd    <= '0;
      r_halted    <= 1'b0;
    end else begin
      r_pend      <= w_pend_next;
      r_alu_valid <= w_fire && w_writes_rd;
      if (w_fire && w_writes_rd) begin
        r_alu_ctrl <= w_ctrl;
        r_op_a     <= w_op_a;
        r_op_b     <= w_op_b;
        r_alu_rd   <= w_instr.rd;
      end
      case (r_state)
        ST_RUN: begin
          if (w_fire && (w_instr.op == OP_HALT)) begin
            r_state  <= ST_HALTED;
            r_halted <= 1'b1;
          end
        end
        ST_HALTED: begin
          r_halted <= 1'b1;
        end
        default: begin
          r_state <= ST_RUN;
        end
      endcase
    end
  end

  assign bus.alu_valid = r_alu_valid;
  assign bus.alu_ctrl  = r_alu_ctrl;
  assign bus.op_a      = r_op_a;
  assign bus.op_b      = r_op_b;
  assign bus.alu_rd    = r_alu_rd;
  assign bus.halted    = r_halted;
  // No opcode holes exist in the current map, so illegal never asserts.
  assign bus.illegal   = 1'b0;

endmodule

// File: tb/tb_operand_issue.sv
// Self-checking bench for operand_issue: directed scenarios plus a random
// run against an instruction-level reference model.
module tb_operand_issue;
  import quad_pkg::*;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  operand_issue_if bus ();

  operand_issue dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: architectural registers, outstanding writes, halt.
  logic [15:0] m_reg [16];
  bit          m_pend [16];
  bit          m_halted;

  // Expectations and observations from the most recent step().
  bit          exp_ready;
  logic        obs_ready;
  bit          exp_valid;
  logic [3:0]  exp_ctrl;
  logic [3:0]  exp_rd;
  logic [15:0] exp_a;
  logic [15:0] exp_b;

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_reg[i]  = 16'h0;
      m_pend[i] = 1'b0;
    end
    m_halted = 1'b0;
  endfunction

  function automatic bit busy(input logic [3:0] r, input logic wv, input logic [3:0] wr);
    return m_pend[r] && !(wv && (wr == r));
  endfunction

  function automatic bit model_ready(input logic [15:0] ins, input logic wv, input logic [3:0] wr);
    logic [3:0] op, rd, ra, rb;
    op = ins[15:12]; rd = ins[11:8]; ra = ins[7:4]; rb = ins[3:0];
    if (m_halted) return 1'b0;
    if (op <= 4'hB) return !(busy(ra, wv, wr) || busy(rb, wv, wr) || busy(rd, wv, wr));
    if (op == 4'hD) return !(busy(ra, wv, wr) || busy(rd, wv, wr));
    if (op == 4'hC) return !busy(rd, wv, wr);
    return 1'b1;
  endfunction

  function automatic logic [15:0] model_read(input logic [3:0] r, input logic wv,
                                             input logic [3:0] wr, input logic [15:0] wd);
    if (r == 4'h0) return 16'h0;
    if (wv && (wr == r)) return wd;
    return m_reg[r];
  endfunction

  // Drive one cycle, predict the result from the model, advance the clock
  // and leave the bench at posedge+1 with the new outputs settled.
  task automatic step(input logic v, input logic [15:0] ins, input logic wv,
                      input logic [3:0] wr, input logic [15:0] wd);
    logic [3:0] op, rd, ra, rb;
    bit fire, writes;
    op = ins[15:12]; rd = ins[11:8]; ra = ins[7:4]; rb = ins[3:0];
    bus.instr_valid = v;
    bus.instr       = ins;
    bus.wb_valid    = wv;
    bus.wb_rd       = wr;
    bus.wb_data     = wd;
    #1;
    obs_ready = bus.instr_ready;
    exp_ready = model_ready(ins, wv, wr);
    fire      = v && exp_ready;
    writes    = (op <= 4'hD);
    exp_valid = fire && writes;
    if (exp_valid) begin
      exp_rd   = rd;
      exp_ctrl = (op <= 4'hB) ? op : 4'h0;
      exp_a    = (op == 4'hC) ? 16'h0 : model_read(ra, wv, wr, wd);
      if (op == 4'hC)      exp_b = {{8{ra[3]}}, ra, rb};
      else if (op == 4'hD) exp_b = {{12{rb[3]}}, rb};
      else                 exp_b = model_read(rb, wv, wr, wd);
    end
    if (wv && (wr != 4'h0)) m_reg[wr] = wd;
    if (wv) m_pend[wr] = 1'b0;
    if (fire && writes && (rd != 4'h0)) m_pend[rd] = 1'b1;
    if (fire && (op == 4'hF)) m_halted = 1'b1;
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
    bus.wb_valid    = 1'b0;
  endtask

  task automatic do_reset();
    resetn          = 1'b0;
    bus.instr_valid = 1'b0;
    bus.wb_valid    = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  // Return every outstanding result so each scenario starts clean.
  task automatic drain();
    for (int r = 1; r < 16; r++) begin
      if (m_pend[r]) step(1'b0, 16'h0, 1'b1, 4'(r), 16'($urandom));
    end
  endtask

  task automatic test_reset();
    resetn          = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr       = 16'h0123;
    bus.wb_valid    = 1'b0;
    bus.wb_rd       = 4'h0;
    bus.wb_data     = 16'h0;
    model_reset();
    #2;
    n_checks++; if ({bus.alu_valid, bus.alu_ctrl, bus.op_a, bus.op_b, bus.alu_rd} !== 41'h0)
      $display("FAIL reset_bundle: got %h want 0", {bus.alu_valid, bus.alu_ctrl, bus.op_a, bus.op_b, bus.alu_rd}); else n_pass++;
    n_checks++; if ({bus.halted, bus.illegal} !== 2'b00)
      $display("FAIL reset_flags: got %b want 00", {bus.halted, bus.illegal}); else n_pass++;
    n_checks++; if (bus.instr_ready !== 1'b1)
      $display("FAIL reset_ready: got %b want 1", bus.instr_ready); else n_pass++;
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic test_ldi_rr();
    step(1'b1, 16'hC17F, 1'b0, 4'h0, 16'h0);
    n_checks++; if ({bus.alu_valid, bus.op_a, bus.op_b, bus.alu_rd} !== {1'b1, 16'h0000, 16'h007F, 4'h1})
      $display("FAIL ldi_r1: got v=%b a=%h b=%h rd=%h want v=1 a=0000 b=007f rd=1", bus.alu_valid, bus.op_a, bus.op_b, bus.alu_rd); else n_pass++;
    step(1'b1, 16'hC2FE, 1'b0, 4'h0, 16'h0);
    n_checks++; if (obs_ready !== 1'b1)
      $display("FAIL back_to_back_ready: got %b want 1", obs_ready); else n_pass++;
    n_checks++; if ({bus.alu_valid, bus.op_b, bus.alu_rd} !== {1'b1, 16'hFFFE, 4'h2})
      $display("FAIL ldi_r2: got v=%b b=%h rd=%h want v=1 b=fffe rd=2", bus.alu_valid, bus.op_b, bus.alu_rd); else n_pass++;
    step(1'b0, 16'h0, 1'b1, 4'h1, 16'h007F);
    step(1'b0, 16'h0, 1'b1, 4'h2, 16'hFFFE);
    step(1'b1, 16'h0312, 1'b0, 4'h0, 16'h0);
    n_checks++; if ({bus.alu_valid, bus.alu_ctrl, bus.op_a, bus.op_b, bus.alu_rd} !== {1'b1, 4'h0, 16'h007F, 16'hFFFE, 4'h3})
      $display("FAIL add_r3: got v=%b c=%h a=%h b=%h rd=%h want v=1 c=0 a=007f b=fffe rd=3",
               bus.alu_valid, bus.alu_ctrl, bus.op_a, bus.op_b, bus.alu_rd); else n_pass++;
    drain();
  endtask

  task automatic test_raw();
    step(1'b1, 16'hC105, 1'b0, 4'h0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 16'hD211, 1'b0, 4'h0, 16'h0);
      n_checks++; if ({obs_ready, bus.alu_valid} !== 2'b00)
        $display("FAIL raw_stall[%0d]: got ready=%b valid=%b want 0 0", i, obs_ready, bus.alu_valid); else n_pass++;
    end
    step(1'b1, 16'hD211, 1'b1, 4'h1, 16'h0005);
    n_checks++; if (obs_ready !== 1'b1)
      $display("FAIL raw_release: got %b want 1", obs_ready); else n_pass++;
    n_checks++; if ({bus.alu_valid, bus.op_a, bus.op_b, bus.alu_rd} !== {1'b1, 16'h0005, 16'h0001, 4'h2})
      $display("FAIL raw_forward: got v=%b a=%h b=%h rd=%h want v=1 a=0005 b=0001 rd=2", bus.alu_valid, bus.op_a, bus.op_b, bus.alu_rd); else n_pass++;
    drain();
  endtask

  task automatic test_waw();
    step(1'b1, 16'hC401, 1'b0, 4'h0, 16'h0);
    n_checks++; if (bus.alu_valid !== 1'b1)
      $display("FAIL waw_first: got %b want 1", bus.alu_valid); else n_pass++;
    step(1'b1, 16'hC402, 1'b0, 4'h0, 16'h0);
    n_checks++; if ({obs_ready, bus.alu_valid} !== 2'b00)
      $display("FAIL waw_stall: got ready=%b valid=%b want 0 0", obs_ready, bus.alu_valid); else n_pass++;
    step(1'b1, 16'hC402, 1'b1, 4'h4, 16'h0001);
    n_checks++; if ({obs_ready, bus.alu_valid, bus.op_b, bus.alu_rd} !== {1'b1, 1'b1, 16'h0002, 4'h4})
      $display("FAIL waw_second: got ready=%b v=%b b=%h rd=%h want 1 1 0002 4", obs_ready, bus.alu_valid, bus.op_b, bus.alu_rd); else n_pass++;
    drain();
  endtask

  task automatic test_r0();
    step(1'b0, 16'h0, 1'b1, 4'h0, 16'h1234);
    step(1'b1, 16'h0500, 1'b0, 4'h0, 16'h0);
    n_checks++; if ({bus.alu_valid, bus.op_a, bus.op_b, bus.alu_rd} !== {1'b1, 16'h0, 16'h0, 4'h5})
      $display("FAIL r0_read: got v=%b a=%h b=%h rd=%h want 1 0000 0000 5", bus.alu_valid, bus.op_a, bus.op_b, bus.alu_rd); else n_pass++;
    step(1'b1, 16'hC0AB, 1'b0, 4'h0, 16'h0);
    step(1'b1, 16'h0600, 1'b0, 4'h0, 16'h0);
    n_checks++; if ({obs_ready, bus.alu_valid, bus.op_a, bus.op_b} !== {1'b1, 1'b1, 16'h0, 16'h0})
      $display("FAIL r0_no_stall: got ready=%b v=%b a=%h b=%h want 1 1 0000 0000", obs_ready, bus.alu_valid, bus.op_a, bus.op_b); else n_pass++;
    drain();
  endtask

  task automatic test_halt();
    step(1'b1, 16'hE000, 1'b0, 4'h0, 16'h0);
    n_checks++; if ({bus.alu_valid, bus.halted} !== 2'b00)
      $display("FAIL nop: got valid=%b halted=%b want 0 0", bus.alu_valid, bus.halted); else n_pass++;
    step(1'b1, 16'hF000, 1'b0, 4'h0, 16'h0);
    n_checks++; if ({bus.alu_valid, bus.halted} !== 2'b01)
      $display("FAIL halt: got valid=%b halted=%b want 0 1", bus.alu_valid, bus.halted); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 16'($urandom), 1'($urandom), 4'($urandom), 16'($urandom));
      n_checks++; if ({obs_ready, bus.alu_valid, bus.halted} !== 3'b001)
        $display("FAIL halted_frozen[%0d]: got ready=%b v=%b halted=%b want 0 0 1", i, obs_ready, bus.alu_valid, bus.halted); else n_pass++;
    end
    do_reset();
    bus.instr = 16'h0123;
    #1;
    n_checks++; if ({bus.instr_ready, bus.halted} !== 2'b10)
      $display("FAIL halt_reset: got ready=%b halted=%b want 1 0", bus.instr_ready, bus.halted); else n_pass++;
  endtask

  task automatic test_async_reset();
    step(1'b1, 16'hC703, 1'b0, 4'h0, 16'h0);
    bus.instr_valid = 1'b1;
    bus.instr       = 16'hD871;
    #1;
    n_checks++; if ({bus.instr_ready, bus.alu_valid} !== 2'b01)
      $display("FAIL async_pre: got ready=%b valid=%b want 0 1", bus.instr_ready, bus.alu_valid); else n_pass++;
    resetn = 1'b0;
    #1;
    n_checks++; if ({bus.alu_valid, bus.alu_ctrl, bus.op_a, bus.op_b, bus.alu_rd} !== 41'h0)
      $display("FAIL async_bundle: got %h want 0", {bus.alu_valid, bus.alu_ctrl, bus.op_a, bus.op_b, bus.alu_rd}); else n_pass++;
    n_checks++; if (bus.instr_ready !== 1'b1)
      $display("FAIL async_pend: got ready=%b want 1", bus.instr_ready); else n_pass++;
    bus.instr_valid = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    step(1'b0, 16'h0, 1'b1, 4'h7, 16'h0055);
    step(1'b1, 16'h0970, 1'b0, 4'h0, 16'h0);
    n_checks++; if ({bus.alu_valid, bus.op_a, bus.op_b} !== {1'b1, 16'h0055, 16'h0000})
      $display("FAIL async_late_wb: got v=%b a=%h b=%h want 1 0055 0000", bus.alu_valid, bus.op_a, bus.op_b); else n_pass++;
    drain();
  endtask

  task automatic test_random();
    logic [3:0] q[$];
    logic [3:0] wr;
    logic       wv;
    logic [15:0] ins;
    for (int c = 0; c < 400; c++) begin
      wv = 1'b0;
      wr = 4'h0;
      if ((q.size() > 0) && ($urandom_range(0, 2) == 0)) begin
        wv = 1'b1;
        wr = q.pop_front();
      end else if ($urandom_range(0, 9) == 0) begin
        wv = 1'b1;
        wr = 4'($urandom);
      end
      ins = {4'($urandom_range(0, 14)), 1'b0, 3'($urandom), 1'b0, 3'($urandom), 4'($urandom)};
      step(1'($urandom_range(0, 4) != 0), ins, wv, wr, 16'($urandom));
      n_checks++; if (obs_ready !== exp_ready)
        $display("FAIL rand_ready[%0d]: got %b want %b", c, obs_ready, exp_ready); else n_pass++;
      n_checks++; if (bus.alu_valid !== exp_valid)
        $display("FAIL rand_valid[%0d]: got %b want %b", c, bus.alu_valid, exp_valid); else n_pass++;
      if (exp_valid) begin
        n_checks++; if ({bus.alu_ctrl, bus.op_a, bus.op_b, bus.alu_rd} !== {exp_ctrl, exp_a, exp_b, exp_rd})
          $display("FAIL rand_bundle[%0d]: got c=%h a=%h b=%h rd=%h want c=%h a=%h b=%h rd=%h", c,
                   bus.alu_ctrl, bus.op_a, bus.op_b, bus.alu_rd, exp_ctrl, exp_a, exp_b, exp_rd); else n_pass++;
        if (exp_rd != 4'h0) q.push_back(exp_rd);
      end
    end
    while (q.size() > 0) step(1'b0, 16'h0, 1'b1, q.pop_front(), 16'($urandom));
    drain();
  endtask

  initial begin
    test_reset();
    test_ldi_rr();
    test_raw();
    test_waw();
    test_r0();
    test_async_reset();
    test_random();
    test_halt();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish within 500000 time units");
    $fatal(1, "timeout");
  end

endmodule
